// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the IF/DM requesters, the shared memory and
// imem_dmem_arbiter.
//   slave  : arbiter view. It takes the requests and memory read data, and it
//            drives done, rdata, wait, busy and the memory command.
//   master : environment view (pipeline plus memory).
interface imem_dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              i_flush;
  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_done;
  logic [DATA_W-1:0] o_if_rdata;
  logic              o_if_wait;
  logic              i_dm_req;
  logic              i_dm_we;
  logic [ADDR_W-1:0] i_dm_addr;
  logic [DATA_W-1:0] i_dm_wdata;
  logic [BE_W-1:0]   i_dm_be;
  logic              o_dm_done;
  logic [DATA_W-1:0] o_dm_rdata;
  logic              o_busy;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [BE_W-1:0]   o_mem_be;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_flush, i_if_req, i_if_addr,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
    input  i_mem_rdata,
    output o_if_done, o_if_rdata, o_if_wait,
    output o_dm_done, o_dm_rdata, o_busy,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );

  modport master (
    output i_flush, i_if_req, i_if_addr,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
    output i_mem_rdata,
    input  o_if_done, o_if_rdata, o_if_wait,
    input  o_dm_done, o_dm_rdata, o_busy,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch (IF)
// and data memory (DM). Each access takes the following path:
//   IDLE -> ACCESS (MEM_LAT+1 cycles) -> RESP (one-cycle done pulse).
// DM has priority over IF. A branch flush drops a pending or in-flight fetch.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : imem_dmem_arbiter_if.slave, which carries the requests,
//              responses, status and memory command
//   o_cnt_*  : performance counters, present only with MEM_ARB_PERF_EN
// Optional feature macro: MEM_ARB_PERF_EN
module imem_dmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  imem_dmem_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         o_cnt_if_stall,
  output logic [31:0]         o_cnt_dm_acc,
  output logic [15:0]         o_cnt_flush_drop
`endif
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner_dm;
  logic             owner_we;
  logic             abort;

  // The fetch stalls until its done pulse is seen.
  assign bus.o_if_wait = bus.i_if_req & ~bus.o_if_done;

  // Main sequencer: arbitration, memory command, response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      owner_dm        <= 1'b0;
      owner_we        <= 1'b0;
      abort           <= 1'b0;
      bus.o_if_done   <= 1'b0;
      bus.o_if_rdata  <= '0;
      bus.o_dm_done   <= 1'b0;
      bus.o_dm_rdata  <= '0;
      bus.o_busy      <= 1'b0;
      bus.o_mem_en    <= 1'b0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
      bus.o_mem_be    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.i_dm_req) begin
            state           <= ACCESS;
            bus.o_busy      <= 1'b1;
            bus.o_mem_en    <= 1'b1;
            bus.o_mem_we    <= bus.i_dm_we;
            bus.o_mem_addr  <= bus.i_dm_addr;
            bus.o_mem_wdata <= bus.i_dm_wdata;
            bus.o_mem_be    <= bus.i_dm_be;
            owner_dm        <= 1'b1;
            owner_we        <= bus.i_dm_we;
            cnt             <= CNT_W'(MEM_LAT);
          end else if (bus.i_if_req && !bus.i_flush) begin
            state           <= ACCESS;
            bus.o_busy      <= 1'b1;
            bus.o_mem_en    <= 1'b1;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_addr  <= bus.i_if_addr;
            bus.o_mem_wdata <= '0;
            bus.o_mem_be    <= '1;
            owner_dm        <= 1'b0;
            owner_we        <= 1'b0;
            cnt             <= CNT_W'(MEM_LAT);
          end
        end

        ACCESS: begin
          // The enable is a single-cycle strobe. The address and data are
          // held for the rest of the access.
          bus.o_mem_en <= 1'b0;
          bus.o_mem_we <= 1'b0;
          if (!owner_dm && bus.i_flush) begin
            abort <= 1'b1;
          end
          if (cnt == '0) begin
            state <= RESP;
            if (owner_dm) begin
              bus.o_dm_done <= 1'b1;
              if (!owner_we) begin
                bus.o_dm_rdata <= bus.i_mem_rdata;
              end
            end else if (!(abort || bus.i_flush)) begin
              // A flush that lands on the final cycle still drops the fetch.
              bus.o_if_done  <= 1'b1;
              bus.o_if_rdata <= bus.i_mem_rdata;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RESP: begin
          // Requests are ignored here, so a requester that drops its request
          // after seeing done is never granted a second time.
          state         <= IDLE;
          bus.o_busy    <= 1'b0;
          bus.o_if_done <= 1'b0;
          bus.o_dm_done <= 1'b0;
          abort         <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  // Performance counters. They wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_cnt_if_stall   <= '0;
      o_cnt_dm_acc     <= '0;
      o_cnt_flush_drop <= '0;
    end else begin
      if (bus.o_if_wait) begin
        o_cnt_if_stall <= o_cnt_if_stall + 32'd1;
      end
      if (state == IDLE && bus.i_dm_req) begin
        o_cnt_dm_acc <= o_cnt_dm_acc + 32'd1;
      end
      if (state == RESP && abort) begin
        o_cnt_flush_drop <= o_cnt_flush_drop + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with MEM_LAT=2. It contains a small
// memory model with a read pipeline and byte-enable writes.
module tb_imem_dmem_arbiter;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MEM_LAT = 2;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  imem_dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] cnt_if_stall;
  logic [31:0] cnt_dm_acc;
  logic [15:0] cnt_flush_drop;
`endif

  imem_dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .o_cnt_if_stall   (cnt_if_stall),
    .o_cnt_dm_acc     (cnt_dm_acc),
    .o_cnt_flush_drop (cnt_flush_drop)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model. The preload is applied while rst is high. Read data
  // appears MEM_LAT cycles after the enable cycle, and junk is returned
  // otherwise.
  logic [31:0] mem  [256];
  logic [31:0] pipe [MEM_LAT];
  logic [7:0]  idx;
  assign idx = bus.o_mem_addr[9:2];

  always @(posedge clk) begin
    if (rst) begin
      mem[64]  <= 32'hDEADBEEF;
      mem[65]  <= 32'hCAFEF00D;
      mem[66]  <= 32'h0BADF00D;
      mem[128] <= 32'h11223344;
    end else if (bus.o_mem_en && bus.o_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.o_mem_be[b]) mem[idx][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
      end
    end
    pipe[0] <= bus.o_mem_en ? mem[idx] : 32'hBAD0BAD0;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.i_mem_rdata = pipe[MEM_LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_flush    = 1'b0;
    bus.i_if_req   = 1'b0;
    bus.i_if_addr  = '0;
    bus.i_dm_req   = 1'b0;
    bus.i_dm_we    = 1'b0;
    bus.i_dm_addr  = '0;
    bus.i_dm_wdata = '0;
    bus.i_dm_be    = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    chk({tag, "_if_done"},   64'(bus.o_if_done),   64'd0);
    chk({tag, "_if_rdata"},  64'(bus.o_if_rdata),  64'd0);
    chk({tag, "_if_wait"},   64'(bus.o_if_wait),   64'd0);
    chk({tag, "_dm_done"},   64'(bus.o_dm_done),   64'd0);
    chk({tag, "_dm_rdata"},  64'(bus.o_dm_rdata),  64'd0);
    chk({tag, "_busy"},      64'(bus.o_busy),      64'd0);
    chk({tag, "_mem_en"},    64'(bus.o_mem_en),    64'd0);
    chk({tag, "_mem_addr"},  64'(bus.o_mem_addr),  64'd0);
    chk({tag, "_mem_wdata"}, 64'(bus.o_mem_wdata), 64'd0);
    chk({tag, "_mem_be"},    64'(bus.o_mem_be),    64'd0);
    next_cycle();
  endtask

  // Runs a single IF read. The request is held until done and dropped the
  // cycle after.
  task automatic run_if(input logic [31:0] addr, input logic [31:0] data, input string tag);
    bus.i_if_addr = addr;
    for (int k = 0; k <= 5; k++) begin
      bus.i_if_req = (k <= 4);
      @(negedge clk);
      chk($sformatf("%s_en_c%0d", tag, k),   64'(bus.o_mem_en),  64'(k == 1));
      chk($sformatf("%s_done_c%0d", tag, k), 64'(bus.o_if_done), 64'(k == 4));
      chk($sformatf("%s_wait_c%0d", tag, k), 64'(bus.o_if_wait), 64'(k <= 3));
      chk($sformatf("%s_busy_c%0d", tag, k), 64'(bus.o_busy),    64'(k >= 1 && k <= 4));
      if (k == 1) begin
        chk({tag, "_addr"}, 64'(bus.o_mem_addr), 64'(addr));
        chk({tag, "_we"},   64'(bus.o_mem_we),   64'd0);
        chk({tag, "_be"},   64'(bus.o_mem_be),   64'hF);
      end
      if (k == 4) chk({tag, "_rdata"}, 64'(bus.o_if_rdata), 64'(data));
      next_cycle();
    end
    bus.i_if_req = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    do_reset();
    check_reset("rst0");
`ifdef MEM_ARB_PERF_EN
    chk("rst0_cnt_stall", 64'(cnt_if_stall), 64'd0);
    chk("rst0_cnt_dm",    64'(cnt_dm_acc),   64'd0);
`endif

    // Plain IF read.
    run_if(32'h100, 32'hDEADBEEF, "s1");

    // Simultaneous IF and DM write requests. DM wins and IF waits.
    do_reset();
    bus.i_if_addr  = 32'h104;
    bus.i_dm_we    = 1'b1;
    bus.i_dm_addr  = 32'h200;
    bus.i_dm_wdata = 32'hAABBCCDD;
    bus.i_dm_be    = 4'h3;
    for (int k = 0; k <= 10; k++) begin
      bus.i_dm_req = (k <= 4);
      bus.i_if_req = (k <= 9);
      @(negedge clk);
      chk($sformatf("s2_en_c%0d", k),     64'(bus.o_mem_en),  64'(k == 1 || k == 6));
      chk($sformatf("s2_dmdone_c%0d", k), 64'(bus.o_dm_done), 64'(k == 4));
      chk($sformatf("s2_ifdone_c%0d", k), 64'(bus.o_if_done), 64'(k == 9));
      chk($sformatf("s2_wait_c%0d", k),   64'(bus.o_if_wait), 64'(k <= 8));
      if (k == 1) begin
        chk("s2_dm_addr", 64'(bus.o_mem_addr), 64'h200);
        chk("s2_dm_we",   64'(bus.o_mem_we),   64'd1);
        chk("s2_dm_be",   64'(bus.o_mem_be),   64'h3);
      end
      if (k == 4) chk("s2_dm_rdata_kept", 64'(bus.o_dm_rdata), 64'd0);
      if (k == 6) chk("s2_if_addr", 64'(bus.o_mem_addr), 64'h104);
      if (k == 9) chk("s2_if_rdata", 64'(bus.o_if_rdata), 64'hCAFEF00D);
      next_cycle();
    end
`ifdef MEM_ARB_PERF_EN
    chk("s2_cnt_dm",    64'(cnt_dm_acc),   64'd1);
    chk("s2_cnt_stall", 64'(cnt_if_stall), 64'd9);
`endif

    // A DM read returns the byte-merged result of the earlier write.
    bus.i_dm_we = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      bus.i_dm_req = (k <= 4);
      @(negedge clk);
      chk($sformatf("dr_en_c%0d", k),   64'(bus.o_mem_en),  64'(k == 1));
      chk($sformatf("dr_done_c%0d", k), 64'(bus.o_dm_done), 64'(k == 4));
      if (k == 4) chk("dr_rdata", 64'(bus.o_dm_rdata), 64'h1122CCDD);
      next_cycle();
    end
    bus.i_dm_req = 1'b0;

    // A flush during an in-flight IF access drops the response.
    do_reset();
    run_if(32'h100, 32'hDEADBEEF, "pre");
    bus.i_if_addr = 32'h104;
    for (int k = 0; k <= 6; k++) begin
      bus.i_if_req = (k <= 2);
      bus.i_flush  = (k == 2);
      @(negedge clk);
      chk($sformatf("s3_en_c%0d", k),   64'(bus.o_mem_en),  64'(k == 1));
      chk($sformatf("s3_done_c%0d", k), 64'(bus.o_if_done), 64'd0);
      chk($sformatf("s3_busy_c%0d", k), 64'(bus.o_busy),    64'(k >= 1 && k <= 4));
      next_cycle();
    end
    bus.i_flush = 1'b0;
    @(negedge clk);
    chk("s3_rdata_kept", 64'(bus.o_if_rdata), 64'hDEADBEEF);
`ifdef MEM_ARB_PERF_EN
    chk("s3_cnt_drop", 64'(cnt_flush_drop), 64'd1);
`endif
    next_cycle();

    // A flush in the cycle the request rises blocks only that cycle's grant.
    bus.i_if_addr = 32'h108;
    for (int k = 0; k <= 6; k++) begin
      bus.i_if_req = (k <= 5);
      bus.i_flush  = (k == 0);
      @(negedge clk);
      chk($sformatf("s4_en_c%0d", k),   64'(bus.o_mem_en),  64'(k == 2));
      chk($sformatf("s4_done_c%0d", k), 64'(bus.o_if_done), 64'(k == 5));
      chk($sformatf("s4_busy_c%0d", k), 64'(bus.o_busy),    64'(k >= 2 && k <= 5));
      if (k == 5) chk("s4_rdata", 64'(bus.o_if_rdata), 64'h0BADF00D);
      next_cycle();
    end
    bus.i_if_req = 1'b0;

    // A reset in the middle of ACCESS abandons the access without a done pulse.
    bus.i_if_addr = 32'h104;
    for (int k = 0; k <= 2; k++) begin
      bus.i_if_req = (k <= 1);
      rst          = (k == 2);
      @(negedge clk);
      chk($sformatf("s5_en_c%0d", k), 64'(bus.o_mem_en), 64'(k == 1));
      next_cycle();
    end
    rst = 1'b0;
    check_reset("s5_rst");
    @(negedge clk);
    chk("s5_no_done", 64'(bus.o_if_done), 64'd0);
    next_cycle();
    run_if(32'h108, 32'h0BADF00D, "s5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
